// File: rtl/sif_pkg.sv
// Shared SIF definitions: frame layout, field offsets and receiver states.
// Intended to be imported by both the address initiator and responder.
package sif_pkg;

    typedef enum logic [1:0] {
        Idle,
        Recv,
        Latch,
        Error
    } sif_rx_state_e;

    localparam int SIF_FRAME_BITS = 12;
    localparam int SIF_ADDR_W     = 4;
    localparam int SIF_SEL_W      = 1 << SIF_ADDR_W;

    localparam int SIF_TX1_LSB = 8;
    localparam int SIF_TX2_LSB = 4;
    localparam int SIF_RX_LSB  = 0;

    function automatic logic [SIF_ADDR_W-1:0] sif_field(
        input logic [SIF_FRAME_BITS-1:0] word,
        input int                        lsb
    );
        return SIF_ADDR_W'(word >> lsb);
    endfunction

    function automatic logic [SIF_SEL_W-1:0] sif_onehot(
        input logic [SIF_ADDR_W-1:0] addr
    );
        return SIF_SEL_W'(1) << addr;
    endfunction

endpackage

// File: rtl/sif_sync_edge.sv
// N-stage synchroniser with rising-edge detect on the synchronised level.
// rise_o is high for one clk_i cycle per low-to-high transition of d_i.
module sif_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    assign w_level = r_sync[STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_i};
            r_prev <= w_level;
        end
    end

    assign rise_o = w_level & ~r_prev;

endmodule

// File: rtl/sif_address_rx.sv
// SIF address responder: oversamples spi_clk/spi_data, assembles a 12-bit
// frame and decodes it into one-hot selects. Option: SIF_ADDR_RX_CLASH_CHK_EN.
module sif_address_rx
    import sif_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FRAME_BITS     = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      spi_clk_i,
    input  logic                      spi_data_i,
    input  logic                      err_clr_i,
    output logic [SIF_SEL_W-1:0]      tx_sel_1_o,
    output logic [SIF_SEL_W-1:0]      tx_sel_2_o,
    output logic [SIF_SEL_W-1:0]      rx_sel_o,
    output logic                      valid_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [SIF_FRAME_BITS-1:0] rx_word_mon_o
`ifdef SIF_ADDR_RX_CLASH_CHK_EN
    ,
    output logic                      clash_o
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_SAT  = '1;
    localparam logic [3:0]    CNT_LAST = 4'(FRAME_BITS - 1);

    sif_rx_state_e r_state;
    sif_rx_state_e w_state_nxt;

    logic                      w_edge;
    logic                      w_data;
    logic [SYNC_STAGES-1:0]    r_data_sync;
    logic [SIF_FRAME_BITS-1:0] r_shift;
    logic [3:0]                r_cnt;
    logic [TW-1:0]             r_timer;
    logic                      w_timeout;

    logic [SIF_ADDR_W-1:0]     w_tx1;
    logic [SIF_ADDR_W-1:0]     w_tx2;
    logic [SIF_ADDR_W-1:0]     w_rx;

    sif_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_clk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi_clk_i),
        .rise_o (w_edge)
    );

    // Data path matches the clock path depth so the bit lines up with the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data_sync <= '0;
        end else begin
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spi_data_i};
        end
    end

    assign w_data    = r_data_sync[SYNC_STAGES-1];
    assign w_timeout = (r_timer == TMR_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= Idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            Idle: begin
                if (en_i && w_edge) begin
                    w_state_nxt = Recv;
                end
            end
            Recv: begin
                if (!en_i) begin
                    w_state_nxt = Idle;
                end else if (w_edge && (r_cnt == CNT_LAST)) begin
                    w_state_nxt = Latch;
                end else if (!w_edge && w_timeout) begin
                    w_state_nxt = Error;
                end
            end
            Latch:   w_state_nxt = Idle;
            Error:   w_state_nxt = Idle;
            default: w_state_nxt = Idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
        end else begin
            unique case (r_state)
                Idle: begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                    r_timer <= '0;
                    if (en_i && w_edge) begin
                        r_shift[0] <= w_data;
                        r_cnt      <= 4'd1;
                    end
                end
                Recv: begin
                    if (w_edge) begin
                        r_shift[r_cnt] <= w_data;
                        r_cnt          <= r_cnt + 4'd1;
                        r_timer        <= '0;
                    end else if (r_timer != TMR_SAT) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign w_tx1 = sif_field(r_shift, SIF_TX1_LSB);
    assign w_tx2 = sif_field(r_shift, SIF_TX2_LSB);
    assign w_rx  = sif_field(r_shift, SIF_RX_LSB);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_sel_1_o    <= '0;
            tx_sel_2_o    <= '0;
            rx_sel_o      <= '0;
            rx_word_mon_o <= '0;
            valid_o       <= 1'b0;
`ifdef SIF_ADDR_RX_CLASH_CHK_EN
            clash_o       <= 1'b0;
`endif
        end else begin
            valid_o <= (r_state == Latch);
            if (r_state == Latch) begin
                rx_word_mon_o <= r_shift;
                tx_sel_1_o    <= sif_onehot(w_tx1);
                rx_sel_o      <= sif_onehot(w_rx);
`ifdef SIF_ADDR_RX_CLASH_CHK_EN
                // Equal tx addresses would double-drive one line; keep tx1 only.
                clash_o       <= (w_tx1 == w_tx2);
                tx_sel_2_o    <= (w_tx1 == w_tx2) ? '0 : sif_onehot(w_tx2);
`else
                tx_sel_2_o    <= sif_onehot(w_tx2);
`endif
            end
        end
    end

    // A timeout in the same cycle as a clear still leaves the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (r_state == Error) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

    assign busy_o = (r_state == Recv) || (r_state == Latch);

endmodule

// File: doc/sif_address_rx.md
Name: sif_address_rx

Overview:
- Responder end of the serial-interface (SIF) address link.
- Sits on the switch-matrix side. Deserialises the 12-bit address frame {tx_add_1, tx_add_2, rx_add} driven on spi_clk/spi_data by the SIF address initiator.
- Decodes the frame into three one-hot 16-way channel selects and flags malformed (timed-out) frames.
- All logic runs on the local system clock; SPI inputs are oversampled.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser for spi_clk_i and spi_data_i (minimum 2).
- TIMEOUT_CYCLES, 64, clk_i cycles allowed between consecutive spi_clk rising edges inside a frame before abort.
- FRAME_BITS, 12, bits per frame (fixed protocol value; not to be overridden).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- en_i  input  1  receiver enable; low forces Idle and ignores SPI inputs
- spi_clk_i  input  1  serial clock from initiator (asynchronous to clk_i)
- spi_data_i  input  1  serial data from initiator
- err_clr_i  input  1  one-cycle pulse, clears err_o
- tx_sel_1_o  output  16  one-hot select for transmitter 1
- tx_sel_2_o  output  16  one-hot select for transmitter 2
- rx_sel_o  output  16  one-hot select for receiver
- valid_o  output  1  one-cycle pulse when selects update
- busy_o  output  1  high while a frame is in progress
- err_o  output  1  sticky frame-timeout flag
- rx_word_mon_o  output  12  last accepted raw frame

Behaviour:
- Protocol: a frame is 12 bits, LSB first. Frame word bit[i] is sampled on the i-th spi_clk rising edge. Word layout is [11:8]=tx_add_1, [7:4]=tx_add_2, [3:0]=rx_add. spi_clk idles low; data is stable while spi_clk is high.
- Synchronisation: spi_clk_i and spi_data_i each pass through SYNC_STAGES flops. The rising edge is detected from the last two synchronised spi_clk samples. The data bit is taken from the synchronised data in the same cycle the edge is detected.
- FSM states are Idle, Recv, Latch, Error.
  - Idle: shift register and bit count are cleared. On a detected edge with en_i=1, store bit0, bit count=1, go to Recv.
  - Recv: each detected edge stores the bit at position count and increments count. Edge with count==11: store bit11, go to Latch. Timer reaching TIMEOUT_CYCLES-1 with no edge: go to Error.
  - Latch (1 cycle): decode the word into selects, update rx_word_mon_o, pulse valid_o, go to Idle.
  - Error (1 cycle): set err_o, discard the partial word, go to Idle. Selects and monitor are unchanged.
- Timer: reset on every detected edge and on entry to Recv; saturates.
- busy_o = (state==Recv || state==Latch).
- Decode: each sel = 16'b1 << field. Outputs are registered and change only in Latch.
- Edge detected in the same cycle the FSM is in Latch: ignored. The initiator's frame gap (≥1 Done + Idle cycle) guarantees this never occurs in legal traffic.
- en_i low in Recv: abort to Idle next cycle. No err_o, no valid_o.
- err_o: set on Error, cleared by err_clr_i or rst_i. If set and clear happen in the same cycle, set wins.
- Reset values: all selects 0, valid_o 0, busy_o 0, err_o 0, rx_word_mon_o 0, state Idle, synchroniser flops 0.
- Reset mid-frame: partial word discarded; outputs return to reset values on the next edge.
- Latency: valid_o asserts SYNC_STAGES+2 clk_i cycles after the 12th spi_clk rising edge at the pin.

Optional Feature:
- Macro: SIF_ADDR_RX_CLASH_CHK_EN.
- Defined: adds output port clash_o (1 bit).
  - In Latch, if tx_add_1==tx_add_2, clash_o is set, and tx_sel_2_o is forced to 0 (only tx_sel_1_o driven), preventing a double-drive of one line.
  - clash_o is registered, updated in every Latch, reset 0.
- Undefined: no clash_o port; tx_sel_2_o is always decoded. Continuity-mode frames with equal tx addresses pass through unchanged.

Decomposition:
- Shared package sif_pkg holds:
  - state enum sif_rx_state_e {Idle, Recv, Latch, Error}
  - SIF_FRAME_BITS=12 and SIF_ADDR_W=4
  - field offsets SIF_TX1_LSB=8, SIF_TX2_LSB=4, SIF_RX_LSB=0
- The initiator is to be migrated to the same package.
- One natural sub-module: sif_sync_edge (N-stage synchroniser plus rising-edge detect), instantiated for spi_clk; spi_data uses a plain synchroniser of matching depth.

Test Plan:
- Send frame tx1=3, tx2=9, rx=12 (word 0x39C) at spi_clk = clk_i/2 -> after the 12th edge: valid_o one pulse, tx_sel_1_o=0x0008, tx_sel_2_o=0x0200, rx_sel_o=0x1000, rx_word_mon_o=0x39C, err_o=0.
- Send 5 bits then hold spi_clk low for 64 cycles -> err_o=1, no valid_o, selects keep previous values. Then pulse err_clr_i -> err_o=0. Then a full frame 0xFFF -> all three selects=0x8000.
- Back-to-back frames 0x123 then 0x456 with 2-cycle gap -> two valid_o pulses; final tx_sel_1_o=0x0010, tx_sel_2_o=0x0020, rx_sel_o=0x0040.
- Drop en_i after 6 bits, re-raise, send 0x0A5 -> no err_o; single valid_o with tx_sel_1_o=0x0001, tx_sel_2_o=0x0400, rx_sel_o=0x0020.
- Assert rst_i mid-frame after 7 bits -> all outputs 0 next cycle; the following full frame decodes correctly.
- With SIF_ADDR_RX_CLASH_CHK_EN, send 0x552 -> clash_o=1, tx_sel_1_o=0x0020, tx_sel_2_o=0, rx_sel_o=0x0004. Without the macro, the same frame gives tx_sel_2_o=0x0020.
